ssp_tx_serializer: RTL

Transmit serializer for the SSP path, clocked directly by the divided SSPCLK. It buffers parallel words from the register side in a small FIFO and shifts each out MSB-first as a Motorola SPI frame (CPOL=0, CPHA=0) on SSPTXD, SSPCLKOUT and SSPFSSOUT. It is the first consumer of SSPCLK and drives the SSP pads.

---
 rtl/ssp_pkg.sv | 26 ++
 rtl/ssp_tx_fifo.sv | 68 ++++++
 rtl/ssp_tx_serializer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP transmit path.
package ssp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } ssp_state_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Ceiling log2, usable in constant expressions; returns 0 for values <= 1.
  function automatic int ssp_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ssp_tx_fifo.sv
// Synchronous TX FIFO with registered full/empty flags and an occupancy count.
module ssp_tx_fifo
  import ssp_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            clear,
  input  logic                            push,
  input  logic                            pop,
  input  logic [DATA_W-1:0]               wdata,
  output logic [DATA_W-1:0]               head,
  output logic                            full,
  output logic                            empty,
  output logic [ssp_clog2(FIFO_DEPTH):0]  count
);

  localparam int AW = ssp_clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count_n;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Next occupancy from accepted push/pop.
  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers and flags; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count_n;
      full  <= (count_n == DEPTH_C);
      empty <= (count_n == CW'(0));
    end
  end

endmodule

// File: rtl/ssp_tx_serializer.sv
// SSP transmit serializer: TX FIFO plus Motorola SPI (CPOL=0, CPHA=0) frame shifter.
// Optional TXINTR output is enabled by defining SSP_TXINTR_EN.
module ssp_tx_serializer
  import ssp_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CLK_DIV    = 2
) (
  input  logic              SSPCLK,
  input  logic              CLEAR,
  input  logic              SSE,
  input  logic [DATA_W-1:0] TXDATA,
  input  logic              TXWR,
  output logic              TXFULL,
  output logic              TXEMPTY,
  output logic              TXOVR,
  output logic              BUSY,
  output logic              SSPCLKOUT,
  output logic              SSPFSSOUT,
  output logic              SSPTXD
`ifdef SSP_TXINTR_EN
  ,
  output logic              TXINTR
`endif
);

  localparam int HW = ssp_clog2(CLK_DIV) + 1;
  localparam int BW = ssp_clog2(2 * DATA_W) + 1;
  localparam int CW = ssp_clog2(FIFO_DEPTH) + 1;
  localparam logic [HW-1:0] HALF_TERM = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] GAP_TERM  = HW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_HALF = BW'(2 * DATA_W - 1);

  ssp_state_e        state, state_n;
  logic [HW-1:0]     hcnt, hcnt_n;
  logic [BW-1:0]     halves, halves_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              sclk, sclk_n;
  logic              fss, fss_n;
  logic              txd, txd_n;
  logic              pop;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              ovr;

  ssp_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (SSPCLK),
    .clear (CLEAR),
    .push  (TXWR),
    .pop   (pop),
    .wdata (TXDATA),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame sequencing; hcnt doubles as the gap timer while in GAP.
  always_comb begin
    state_n  = state;
    hcnt_n   = hcnt;
    halves_n = halves;
    shreg_n  = shreg;
    sclk_n   = sclk;
    fss_n    = fss;
    txd_n    = txd;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (SSE && !fifo_empty) begin
          pop      = 1'b1;
          state_n  = ACTIVE;
          shreg_n  = fifo_head;
          fss_n    = 1'b0;
          txd_n    = fifo_head[DATA_W-1];
          hcnt_n   = '0;
          halves_n = '0;
          sclk_n   = 1'b0;
        end else begin
          fss_n  = 1'b1;
          txd_n  = 1'b0;
          sclk_n = 1'b0;
        end
      end
      ACTIVE: begin
        if (hcnt == HALF_TERM) begin
          hcnt_n   = '0;
          halves_n = halves + BW'(1);
          sclk_n   = !sclk;
          if (sclk && (halves == LAST_HALF)) begin
            state_n = GAP;
            fss_n   = 1'b1;
            txd_n   = 1'b0;
          end else if (sclk) begin
            shreg_n = {shreg[DATA_W-2:0], 1'b0};
            txd_n   = shreg[DATA_W-2];
          end else begin
            txd_n = txd;
          end
        end else begin
          hcnt_n = hcnt + HW'(1);
        end
      end
      GAP: begin
        if (hcnt == GAP_TERM) begin
          state_n = IDLE;
          hcnt_n  = '0;
        end else begin
          hcnt_n = hcnt + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        hcnt_n  = '0;
        sclk_n  = 1'b0;
        fss_n   = 1'b1;
        txd_n   = 1'b0;
      end
    endcase
  end

  // Serializer state and pad registers.
  always_ff @(posedge SSPCLK) begin
    if (CLEAR) begin
      state  <= IDLE;
      hcnt   <= '0;
      halves <= '0;
      shreg  <= '0;
      sclk   <= 1'b0;
      fss    <= 1'b1;
      txd    <= 1'b0;
    end else begin
      state  <= state_n;
      hcnt   <= hcnt_n;
      halves <= halves_n;
      shreg  <= shreg_n;
      sclk   <= sclk_n;
      fss    <= fss_n;
      txd    <= txd_n;
    end
  end

  // Sticky overflow: a write against the registered full flag is lost.
  always_ff @(posedge SSPCLK) begin
    if (CLEAR) begin
      ovr <= 1'b0;
    end else if (TXWR && fifo_full) begin
      ovr <= 1'b1;
    end else begin
      ovr <= ovr;
    end
  end

`ifdef SSP_TXINTR_EN
  localparam logic [CW-1:0] HALF_DEPTH = CW'(FIFO_DEPTH / 2);

  // Low-water interrupt, qualified by enable.
  always_ff @(posedge SSPCLK) begin
    if (CLEAR) begin
      TXINTR <= 1'b0;
    end else begin
      TXINTR <= (fifo_count <= HALF_DEPTH) && SSE;
    end
  end
`endif

  assign TXFULL    = fifo_full;
  assign TXEMPTY   = fifo_empty;
  assign TXOVR     = ovr;
  assign BUSY      = (state != IDLE) || (fifo_count != CW'(0));
  assign SSPCLKOUT = sclk;
  assign SSPFSSOUT = fss;
  assign SSPTXD    = txd;

endmodule
